mul_arbiter: RTL

Round-robin arbiter and scheduler that shares one int/fp16 multiplier (`int_fp_mul`) among NREQ requesters. Each requester presents a mode and two 16-bit operands over a valid/ready handshake. The block issues at most one operation per cycle into the multiplier and tracks in-flight operations through a tag pipeline matched to the multiplier latency. It returns results, tagged with the requester index, through a credit-protected response FIFO with its own valid/ready handshake.

---
 rtl/mul_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin scheduler that shares one int/fp16 multiplier
// among NREQ requesters. Issued operations are tracked by a tag pipe
// aligned to the multiplier latency. Results return through a response
// FIFO whose free space is reserved at issue time (credit count).
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. A source holds valid and its payload stable until it sees ready.
// Ready never depends on the payload.
module mul_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 1,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_mode,
   input  logic [16*NREQ-1:0] req_a,
   input  logic [16*NREQ-1:0] req_b,
   output logic               mul_mode,
   output logic [15:0]        mul_a,
   output logic [15:0]        mul_b,
   input  logic [15:0]        mul_c,
   input  logic               mul_error,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [15:0]        rsp_c,
   output logic               rsp_error
);

   localparam int DEPTH = LAT + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);

   logic [IDW-1:0] ptr;
   logic [CW-1:0]  cnt;
   logic           cand_vld;
   logic [IDW-1:0] cand_id;
   logic [IDW-1:0] scan;
   logic           issue;
   logic           pop;

   logic           push_vld;
   logic [IDW-1:0] push_id;
   logic           push_mode;

   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  fcnt;
   logic [IDW-1:0] f_id  [DEPTH];
   logic [15:0]    f_c   [DEPTH];
   logic           f_err [DEPTH];

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search: start one past the last winner and wrap upward.
   always_comb begin
      cand_vld = 1'b0;
      cand_id  = '0;
      scan     = ptr;
      for (int k = 0; k < NREQ; k++) begin
         scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + 1'b1;
         if (!cand_vld && req_valid[scan]) begin
            cand_vld = 1'b1;
            cand_id  = scan;
         end
      end
   end

   // A grant needs a reserved FIFO slot; nothing is granted while in reset.
   assign issue = rst_n & cand_vld & (cnt < CW'(DEPTH));
   assign pop   = rsp_valid & rsp_ready;

   // One-hot grant and multiplier operand mux; all zero when nothing issues.
   always_comb begin
      req_ready = '0;
      mul_mode  = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (issue && cand_id == IDW'(i)) begin
            req_ready[i] = 1'b1;
            mul_mode     = req_mode[i];
            mul_a        = req_a[16*i +: 16];
            mul_b        = req_b[16*i +: 16];
         end
      end
   end

   // Priority pointer remembers the last winner; reset favours requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ptr <= IDW'(NREQ - 1);
      else if (issue) ptr <= cand_id;
   end

   // Credits: one per operation between issue and response pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (issue && !pop)   cnt <= cnt + 1'b1;
      else if (!issue && pop)   cnt <= cnt - 1'b1;
   end

   generate
      if (LAT == 0) begin : g_tag_comb
         // Combinational multiplier: the result is written at the issue edge.
         assign push_vld  = issue;
         assign push_id   = cand_id;
         assign push_mode = mul_mode;
      end else begin : g_tag_pipe
         logic [LAT-1:0]          t_vld;
         logic [LAT-1:0][IDW-1:0] t_id;
         logic [LAT-1:0]          t_mode;

         // Tag shift register running in step with the multiplier pipeline.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               t_vld  <= '0;
               t_id   <= '0;
               t_mode <= '0;
            end else begin
               t_vld[0]  <= issue;
               t_id[0]   <= cand_id;
               t_mode[0] <= mul_mode;
               for (int s = 1; s < LAT; s++) begin
                  t_vld[s]  <= t_vld[s-1];
                  t_id[s]   <= t_id[s-1];
                  t_mode[s] <= t_mode[s-1];
               end
            end
         end

         assign push_vld  = t_vld[LAT-1];
         assign push_id   = t_id[LAT-1];
         assign push_mode = t_mode[LAT-1];
      end
   endgenerate

   // FIFO pointers and occupancy; the credit scheme keeps pushes off a full FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (push_vld) wr_ptr <= wrap_inc(wr_ptr);
         if (pop)      rd_ptr <= wrap_inc(rd_ptr);
         if (push_vld && !pop)      fcnt <= fcnt + 1'b1;
         else if (!push_vld && pop) fcnt <= fcnt - 1'b1;
      end
   end

   // FIFO storage; int results never report an error.
   always_ff @(posedge clk) begin
      if (push_vld) begin
         f_id[wr_ptr]  <= push_id;
         f_c[wr_ptr]   <= mul_c;
         f_err[wr_ptr] <= mul_error & push_mode;
      end
   end

   assign rsp_valid = rst_n & (fcnt != '0);
   assign rsp_id    = rsp_valid ? f_id[rd_ptr]  : '0;
   assign rsp_c     = rsp_valid ? f_c[rd_ptr]   : '0;
   assign rsp_error = rsp_valid ? f_err[rd_ptr] : 1'b0;

endmodule
